gpu_draw_engine: RTL
====================

# gpu_draw_engine

Parametrised draw engine for the Herring GPU: a CPU-facing register file plus a command sequencer that emits pixel writes to the framebuffer write port over a valid/ready handshake. It adds wide coordinates, configurable colour depth, rectangle fill and full-screen clear, and BUSY/ERR status. All logic runs in the pixel-clock domain. The CPU bus is presented as a single-cycle write strobe.

## Interface
- X_WIDTH, 10, bits per X coordinate (≤16)
- Y_WIDTH, 10, bits per Y coordinate (≤16)
- COLOR_BITS, 3, colour depth (≤8)
- SCREEN_W, 800, visible width in pixels (≤2^X_WIDTH)
- SCREEN_H, 600, visible height in pixels (≤2^Y_WIDTH)

Ports:
- PIXEL_CLOCK  in  1  sole clock; all state updates on rising edge
- RESETB  in  1  reset, synchronous, active-low
- RS  in  4  register select
- WR  in  1  one-cycle write strobe; DATA_IN valid with it
- DATA_IN  in  8  CPU write data
- DATA_OUT  out  8  registered read data for RS
- ON_SCREEN  in  1  from VGA timing; reported inverted as VBLANK
- FB_VALID  out  1  pixel write request
- FB_READY  in  1  framebuffer accepts on FB_VALID && FB_READY
- FB_X  out  X_WIDTH  pixel X
- FB_Y  out  Y_WIDTH  pixel Y
- FB_COLOR  out  COLOR_BITS  pixel colour
- BUSY  out  1  command in progress

## Operation
- Register map (RS):
  - 0: COLOR. Holds DATA_IN[COLOR_BITS-1:0].
  - 1/2: X0 lo/hi. 3/4: Y0 lo/hi. 5/6: X1 lo/hi. 7/8: Y1 lo/hi.
  - 9: CMD, write-only; reads return 0.
  - 10: STATUS = {5'b0, VBLANK, ERR, BUSY}.
  - 11–15: reserved; writes are ignored and reads return 0.
- Hi-byte bits above the coordinate width are discarded on write. Reads zero-extend.
- Parameter and coordinate registers may be written while BUSY. The engine works from working copies captured at launch.
- CMD codes:
  - 0x00 PLOT: one pixel at (X0,Y0).
  - 0x01 FILL: rectangle X0..X1 × Y0..Y1, inclusive.
  - 0x02 CLEAR: whole screen filled with COLOR.
  - 0x80 CLR_ERR: clears ERR.
  - Any other code sets ERR and does nothing else.
- A CMD write while BUSY (other than 0x80) is dropped and sets ERR.
- Clipping:
  - PLOT with X0≥SCREEN_W or Y0≥SCREEN_H completes with zero writes and no ERR.
  - FILL clamps X1 to SCREEN_W-1 and Y1 to SCREEN_H-1.
  - FILL with X1<X0 or Y1<Y0, or with X0/Y0 off-screen, completes with zero writes and sets ERR.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on a valid draw command with at least one pixel.
  - IDLE→DONE on a zero-pixel command.
  - RUN emits pixels row-major: X increments; at X=xe, X wraps to xs and Y increments. The last pixel is (xe,ye).
  - RUN→DONE when the last pixel handshake completes.
  - DONE→IDLE unconditionally after one cycle.
- BUSY=1 in RUN and DONE.

## Timing
- Reset values: FB_VALID=0, FB_X=0, FB_Y=0, FB_COLOR=0, BUSY=0, DATA_OUT=0, all registers 0, ERR=0, state IDLE.
- Reset asserted mid-command abandons it immediately. FB_VALID is 0 on the first cycle after the reset edge.
- A CMD write in cycle N gives BUSY=1 and the first FB_VALID=1 with the first pixel in cycle N+1.
- FB_X, FB_Y and FB_COLOR hold stable while FB_VALID && !FB_READY. FB_VALID never drops without a handshake.
- Throughput is 1 pixel/cycle with FB_READY held high. An N-pixel FILL commanded at cycle C has its last handshake at C+N and BUSY low at C+N+2.
- Zero-pixel command: BUSY is high for exactly cycle N+1.
- DATA_OUT reflects RS sampled at cycle N, in cycle N+1.
- Simultaneous WR to CMD and completion of the final pixel: the command is rejected (state is not IDLE) and ERR is set.

## Structure
- gpu_pkg holds:
  - register-address localparams (REG_COLOR … REG_STATUS);
  - CMD codes;
  - STATUS bit indices;
  - the FSM state enum.
- One sub-module, gpu_raster_counter, contains the XY scan counter with start/end bounds, advance and last outputs. It is reusable for a future blit engine.

## Test plan
- PLOT: COLOR=5, X0=0x123, Y0=0x45, CMD=0x00, FB_READY=1 → exactly one handshake (291,69,5); BUSY high 2 cycles.
- FILL X0=2,X1=4,Y0=10,Y1=11, COLOR=3, FB_READY toggling 1/0 → 6 writes in order (2,10)…(4,11), outputs stable while stalled.
- FILL X1=900,Y1=700 with defaults → clamped to 799/599; last write (799,599).
- CMD=0x01 while BUSY → dropped, ERR=1 in STATUS; CMD=0x80 → ERR=0; CMD=0x7F → ERR=1, no writes.
- CLEAR, then RESETB low mid-run for one cycle → FB_VALID=0 and BUSY=0 on the next cycle, all registers read 0.
- Read RS=10 with ON_SCREEN=0 and idle → DATA_OUT=0x04 one cycle later.

Source files
------------

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared definitions for the Herring GPU draw engine.
// Holds the CPU register map, command codes, STATUS bit positions, the
// sequencer state type and two small byte-packing helpers.
package gpu_pkg;

  // CPU register map (RS)
  localparam logic [3:0] REG_COLOR  = 4'd0;
  localparam logic [3:0] REG_X0_LO  = 4'd1;
  localparam logic [3:0] REG_X0_HI  = 4'd2;
  localparam logic [3:0] REG_Y0_LO  = 4'd3;
  localparam logic [3:0] REG_Y0_HI  = 4'd4;
  localparam logic [3:0] REG_X1_LO  = 4'd5;
  localparam logic [3:0] REG_X1_HI  = 4'd6;
  localparam logic [3:0] REG_Y1_LO  = 4'd7;
  localparam logic [3:0] REG_Y1_HI  = 4'd8;
  localparam logic [3:0] REG_CMD    = 4'd9;
  localparam logic [3:0] REG_STATUS = 4'd10;

  // Command codes written to REG_CMD
  localparam logic [7:0] CMD_PLOT    = 8'h00;
  localparam logic [7:0] CMD_FILL    = 8'h01;
  localparam logic [7:0] CMD_CLEAR   = 8'h02;
  localparam logic [7:0] CMD_CLR_ERR = 8'h80;

  // STATUS register bit positions
  localparam int STATUS_BUSY   = 0;
  localparam int STATUS_ERR    = 1;
  localparam int STATUS_VBLANK = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } draw_state_e;

  // Replace the low or high byte of a 16-bit coordinate image.
  function automatic logic [15:0] merge_byte(input logic [15:0] cur,
                                             input logic [7:0]  data,
                                             input logic        hi);
    logic [15:0] res;
    if (hi) begin
      res = {data, cur[7:0]};
    end else begin
      res = {cur[15:8], data};
    end
    return res;
  endfunction

  // Assemble the STATUS byte from its flags.
  function automatic logic [7:0] pack_status(input logic vblank,
                                             input logic err,
                                             input logic busy);
    logic [7:0] s;
    s = 8'h00;
    s[STATUS_VBLANK] = vblank;
    s[STATUS_ERR]    = err;
    s[STATUS_BUSY]   = busy;
    return s;
  endfunction

endpackage

// File: rtl/gpu_raster_counter.sv
// gpu_raster_counter: row-major XY scan counter.
// load    : capture start/end bounds and move to (start_x, start_y)
// advance : step one pixel; X wraps to start_x at end_x and Y increments
// x, y    : current position (registered)
// last    : current position is (end_x, end_y)
module gpu_raster_counter #(
  parameter int X_WIDTH = 10,
  parameter int Y_WIDTH = 10
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic               load,
  input  logic               advance,
  input  logic [X_WIDTH-1:0] start_x,
  input  logic [Y_WIDTH-1:0] start_y,
  input  logic [X_WIDTH-1:0] end_x,
  input  logic [Y_WIDTH-1:0] end_y,
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  output logic               last
);

  logic [X_WIDTH-1:0] xs_r;
  logic [X_WIDTH-1:0] xe_r;
  logic [Y_WIDTH-1:0] ye_r;

  localparam logic [X_WIDTH-1:0] X_ONE = {{(X_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [Y_WIDTH-1:0] Y_ONE = {{(Y_WIDTH-1){1'b0}}, 1'b1};

  // Bounds capture and scan position update
  always_ff @(posedge clk) begin
    if (!resetb) begin
      x    <= {X_WIDTH{1'b0}};
      y    <= {Y_WIDTH{1'b0}};
      xs_r <= {X_WIDTH{1'b0}};
      xe_r <= {X_WIDTH{1'b0}};
      ye_r <= {Y_WIDTH{1'b0}};
    end else if (load) begin
      x    <= start_x;
      y    <= start_y;
      xs_r <= start_x;
      xe_r <= end_x;
      ye_r <= end_y;
    end else if (advance) begin
      if (x == xe_r) begin
        x <= xs_r;
        y <= y + Y_ONE;
      end else begin
        x <= x + X_ONE;
      end
    end else begin
      x <= x;
    end
  end

  assign last = (x == xe_r) && (y == ye_r);

endmodule

// File: rtl/gpu_draw_engine.sv
// gpu_draw_engine: CPU register file plus command sequencer emitting
// framebuffer pixel writes over a valid/ready handshake.
// PIXEL_CLOCK/RESETB : clock, synchronous active-low reset
// RS/WR/DATA_IN      : CPU register select, write strobe and data
// DATA_OUT           : registered read data for RS (one cycle later)
// ON_SCREEN          : VGA timing, reported inverted as VBLANK in STATUS
// FB_VALID/FB_READY  : pixel write handshake; FB_X/FB_Y/FB_COLOR payload
// BUSY               : a command is running or finishing
module gpu_draw_engine
  import gpu_pkg::*;
#(
  parameter int X_WIDTH    = 10,
  parameter int Y_WIDTH    = 10,
  parameter int COLOR_BITS = 3,
  parameter int SCREEN_W   = 800,
  parameter int SCREEN_H   = 600
) (
  input  logic                  PIXEL_CLOCK,
  input  logic                  RESETB,
  input  logic [3:0]            RS,
  input  logic                  WR,
  input  logic [7:0]            DATA_IN,
  output logic [7:0]            DATA_OUT,
  input  logic                  ON_SCREEN,
  output logic                  FB_VALID,
  input  logic                  FB_READY,
  output logic [X_WIDTH-1:0]    FB_X,
  output logic [Y_WIDTH-1:0]    FB_Y,
  output logic [COLOR_BITS-1:0] FB_COLOR,
  output logic                  BUSY
);

  localparam logic [X_WIDTH-1:0] X_LAST       = X_WIDTH'(SCREEN_W - 1);
  localparam logic [Y_WIDTH-1:0] Y_LAST       = Y_WIDTH'(SCREEN_H - 1);
  // 17 bits so a screen dimension of exactly 2^16 still compares correctly
  localparam logic [16:0]        SCREEN_W_EXT = 17'(SCREEN_W);
  localparam logic [16:0]        SCREEN_H_EXT = 17'(SCREEN_H);

  draw_state_e state_r;
  draw_state_e next_state_s;

  logic [COLOR_BITS-1:0] color_r;
  logic [X_WIDTH-1:0]    x0_r;
  logic [Y_WIDTH-1:0]    y0_r;
  logic [X_WIDTH-1:0]    x1_r;
  logic [Y_WIDTH-1:0]    y1_r;
  logic                  err_r;

  logic [15:0] x0_ext_s;
  logic [15:0] y0_ext_s;
  logic [15:0] x1_ext_s;
  logic [15:0] y1_ext_s;

  logic               cmd_wr_s;
  logic               launch_s;
  logic               err_set_s;
  logic               err_clr_s;
  logic               advance_s;
  logic               last_s;
  logic               x0_off_s;
  logic               y0_off_s;
  logic               fill_ok_s;
  logic [X_WIDTH-1:0] x1_clamp_s;
  logic [Y_WIDTH-1:0] y1_clamp_s;
  logic [X_WIDTH-1:0] ld_xs_s;
  logic [Y_WIDTH-1:0] ld_ys_s;
  logic [X_WIDTH-1:0] ld_xe_s;
  logic [Y_WIDTH-1:0] ld_ye_s;
  logic [7:0]         rd_data_s;

  assign x0_ext_s = 16'(x0_r);
  assign y0_ext_s = 16'(y0_r);
  assign x1_ext_s = 16'(x1_r);
  assign y1_ext_s = 16'(y1_r);

  assign cmd_wr_s   = WR && (RS == REG_CMD);
  assign x0_off_s   = 17'(x0_r) >= SCREEN_W_EXT;
  assign y0_off_s   = 17'(y0_r) >= SCREEN_H_EXT;
  assign x1_clamp_s = (17'(x1_r) >= SCREEN_W_EXT) ? X_LAST : x1_r;
  assign y1_clamp_s = (17'(y1_r) >= SCREEN_H_EXT) ? Y_LAST : y1_r;
  assign fill_ok_s  = !x0_off_s && !y0_off_s &&
                      (x1_clamp_s >= x0_r) && (y1_clamp_s >= y0_r);
  // The counter only steps on a handshake that is not the final pixel
  assign advance_s  = FB_VALID && FB_READY && !last_s;

  // Command decode and sequencer next-state
  always_comb begin
    next_state_s = state_r;
    launch_s     = 1'b0;
    err_set_s    = 1'b0;
    err_clr_s    = 1'b0;
    ld_xs_s      = x0_r;
    ld_ys_s      = y0_r;
    ld_xe_s      = x0_r;
    ld_ye_s      = y0_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_wr_s) begin
          case (DATA_IN)
            CMD_PLOT: begin
              if (!x0_off_s && !y0_off_s) begin
                launch_s     = 1'b1;
                next_state_s = ST_RUN;
              end else begin
                next_state_s = ST_DONE;
              end
            end
            CMD_FILL: begin
              ld_xe_s = x1_clamp_s;
              ld_ye_s = y1_clamp_s;
              if (fill_ok_s) begin
                launch_s     = 1'b1;
                next_state_s = ST_RUN;
              end else begin
                err_set_s    = 1'b1;
                next_state_s = ST_DONE;
              end
            end
            CMD_CLEAR: begin
              ld_xs_s      = {X_WIDTH{1'b0}};
              ld_ys_s      = {Y_WIDTH{1'b0}};
              ld_xe_s      = X_LAST;
              ld_ye_s      = Y_LAST;
              launch_s     = 1'b1;
              next_state_s = ST_RUN;
            end
            CMD_CLR_ERR: err_clr_s = 1'b1;
            default:     err_set_s = 1'b1;
          endcase
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cmd_wr_s) begin
          if (DATA_IN == CMD_CLR_ERR) begin
            err_clr_s = 1'b1;
          end else begin
            err_set_s = 1'b1;
          end
        end else begin
          err_set_s = 1'b0;
        end
        if (FB_VALID && FB_READY && last_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (cmd_wr_s) begin
          if (DATA_IN == CMD_CLR_ERR) begin
            err_clr_s = 1'b1;
          end else begin
            err_set_s = 1'b1;
          end
        end else begin
          err_set_s = 1'b0;
        end
        next_state_s = ST_IDLE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Sequencer state, BUSY and sticky ERR
  always_ff @(posedge PIXEL_CLOCK) begin
    if (!RESETB) begin
      state_r <= ST_IDLE;
      BUSY    <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      BUSY    <= (next_state_s != ST_IDLE);
      if (err_clr_s) begin
        err_r <= 1'b0;
      end else if (err_set_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  // Pixel request and the colour captured at launch
  always_ff @(posedge PIXEL_CLOCK) begin
    if (!RESETB) begin
      FB_VALID <= 1'b0;
      FB_COLOR <= {COLOR_BITS{1'b0}};
    end else if (launch_s) begin
      FB_VALID <= 1'b1;
      FB_COLOR <= color_r;
    end else if (FB_VALID && FB_READY && last_s) begin
      FB_VALID <= 1'b0;
    end else begin
      FB_VALID <= FB_VALID;
    end
  end

  // CPU register writes; bits above the coordinate width are dropped
  always_ff @(posedge PIXEL_CLOCK) begin
    if (!RESETB) begin
      color_r <= {COLOR_BITS{1'b0}};
      x0_r    <= {X_WIDTH{1'b0}};
      y0_r    <= {Y_WIDTH{1'b0}};
      x1_r    <= {X_WIDTH{1'b0}};
      y1_r    <= {Y_WIDTH{1'b0}};
    end else if (WR) begin
      case (RS)
        REG_COLOR:            color_r <= DATA_IN[COLOR_BITS-1:0];
        REG_X0_LO, REG_X0_HI: x0_r <= X_WIDTH'(merge_byte(x0_ext_s, DATA_IN, RS == REG_X0_HI));
        REG_Y0_LO, REG_Y0_HI: y0_r <= Y_WIDTH'(merge_byte(y0_ext_s, DATA_IN, RS == REG_Y0_HI));
        REG_X1_LO, REG_X1_HI: x1_r <= X_WIDTH'(merge_byte(x1_ext_s, DATA_IN, RS == REG_X1_HI));
        REG_Y1_LO, REG_Y1_HI: y1_r <= Y_WIDTH'(merge_byte(y1_ext_s, DATA_IN, RS == REG_Y1_HI));
        default:              color_r <= color_r;
      endcase
    end else begin
      color_r <= color_r;
    end
  end

  // Read-data select
  always_comb begin
    rd_data_s = 8'h00;
    case (RS)
      REG_COLOR:  rd_data_s = 8'(color_r);
      REG_X0_LO:  rd_data_s = x0_ext_s[7:0];
      REG_X0_HI:  rd_data_s = x0_ext_s[15:8];
      REG_Y0_LO:  rd_data_s = y0_ext_s[7:0];
      REG_Y0_HI:  rd_data_s = y0_ext_s[15:8];
      REG_X1_LO:  rd_data_s = x1_ext_s[7:0];
      REG_X1_HI:  rd_data_s = x1_ext_s[15:8];
      REG_Y1_LO:  rd_data_s = y1_ext_s[7:0];
      REG_Y1_HI:  rd_data_s = y1_ext_s[15:8];
      REG_STATUS: rd_data_s = pack_status(!ON_SCREEN, err_r, BUSY);
      default:    rd_data_s = 8'h00;
    endcase
  end

  // Registered read port
  always_ff @(posedge PIXEL_CLOCK) begin
    if (!RESETB) begin
      DATA_OUT <= 8'h00;
    end else begin
      DATA_OUT <= rd_data_s;
    end
  end

  gpu_raster_counter #(
    .X_WIDTH (X_WIDTH),
    .Y_WIDTH (Y_WIDTH)
  ) u_raster (
    .clk     (PIXEL_CLOCK),
    .resetb  (RESETB),
    .load    (launch_s),
    .advance (advance_s),
    .start_x (ld_xs_s),
    .start_y (ld_ys_s),
    .end_x   (ld_xe_s),
    .end_y   (ld_ye_s),
    .x       (FB_X),
    .y       (FB_Y),
    .last    (last_s)
  );

endmodule
